// File: rtl/pwm_seq_pkg.sv
// Shared types and default constants for the PWM sequencing controller.
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        RAMP     = 2'd1,
        RUN      = 2'd2,
        SHUTDOWN = 2'd3
    } seq_state_t;

    localparam int DEF_DUTY_W     = 4;
    localparam int DEF_FREQ_W     = 8;
    localparam int DEF_FREQ_MIN   = 1;
    localparam int DEF_FREQ_MAX   = 200;
    localparam int DEF_FREQ_RST   = 100;
    localparam int DEF_TARGET_RST = 8;
    localparam int DEF_RAMP_DIV   = 50000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_seq_if.sv
// Button/enable inputs and PWM-datapath outputs of the sequencer.
interface pwm_seq_if #(
    parameter int DUTY_W = 4,
    parameter int FREQ_W = 8
);
    logic              MEn;
    logic              Modo_i;
    logic              aumC_i;
    logic              bajaC_i;
    logic              aumf_i;
    logic              bajaf_i;
    logic [DUTY_W-1:0] Ref_o;
    logic [DUTY_W-1:0] Target_o;
    logic [FREQ_W-1:0] numF_o;
    logic              PwmEn_o;
    logic              Busy_o;

    modport master (
        output MEn, Modo_i, aumC_i, bajaC_i, aumf_i, bajaf_i,
        input  Ref_o, Target_o, numF_o, PwmEn_o, Busy_o
    );

    modport slave (
        input  MEn, Modo_i, aumC_i, bajaC_i, aumf_i, bajaf_i,
        output Ref_o, Target_o, numF_o, PwmEn_o, Busy_o
    );
endinterface

// File: rtl/ramp_tick.sv
// Ramp-rate prescaler: counts 0..RAMP_DIV-1 while enabled, one-cycle tick on terminal count.
module ramp_tick
    import pwm_seq_pkg::*;
#(
    parameter int RAMP_DIV = DEF_RAMP_DIV
)(
    input  logic clk_sys,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int                CNT_W = cnt_width(RAMP_DIV);
    localparam logic [CNT_W-1:0]  TC    = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (clr || !en || (cnt_q == TC)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && (cnt_q == TC);

endmodule

// File: rtl/pwm_sequencer.sv
// Duty/frequency setpoint holder with soft-start, soft-stop and ramp-mode slewing of the PWM reference.
//
// state    | meaning
// OFF      | PWM disabled, reference parked at 0
// RAMP     | PWM on, reference stepping one count per tick toward the setpoint
// RUN      | PWM on, reference equals the setpoint
// SHUTDOWN | PWM on, reference stepping down to 0 before disabling
module pwm_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int DUTY_W     = DEF_DUTY_W,
    parameter int FREQ_W     = DEF_FREQ_W,
    parameter int FREQ_MIN   = DEF_FREQ_MIN,
    parameter int FREQ_MAX   = DEF_FREQ_MAX,
    parameter int FREQ_RST   = DEF_FREQ_RST,
    parameter int TARGET_RST = DEF_TARGET_RST,
    parameter int RAMP_DIV   = DEF_RAMP_DIV
)(
    input  logic     CLKNEXYS,
    input  logic     MRst,
    pwm_seq_if.slave bus
);
    localparam logic [DUTY_W-1:0] DUTY_TOP = '1;
    localparam logic [FREQ_W-1:0] F_MIN    = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0] F_MAX    = FREQ_W'(FREQ_MAX);

    seq_state_t        state;
    logic [DUTY_W-1:0] ref_q;
    logic [DUTY_W-1:0] target_q;
    logic [DUTY_W-1:0] target_nxt;
    logic [DUTY_W-1:0] ref_step;
    logic [FREQ_W-1:0] numf_q;
    logic [FREQ_W-1:0] numf_nxt;
    logic              pwm_en_q;
    logic              busy_q;
    logic              tick;
    logic              tick_en;
    logic              tick_clr;

    // Saturating setpoint updates; simultaneous up/down cancel.
    always_comb begin
        target_nxt = target_q;
        if (bus.aumC_i && !bus.bajaC_i && (target_q != DUTY_TOP)) begin
            target_nxt = target_q + DUTY_W'(1);
        end else if (bus.bajaC_i && !bus.aumC_i && (target_q != '0)) begin
            target_nxt = target_q - DUTY_W'(1);
        end
    end

    always_comb begin
        numf_nxt = numf_q;
        if (bus.aumf_i && !bus.bajaf_i && (numf_q < F_MAX)) begin
            numf_nxt = numf_q + FREQ_W'(1);
        end else if (bus.bajaf_i && !bus.aumf_i && (numf_q > F_MIN)) begin
            numf_nxt = numf_q - FREQ_W'(1);
        end
    end

    assign ref_step = (ref_q < target_nxt) ? ref_q + DUTY_W'(1) : ref_q - DUTY_W'(1);
    assign tick_en  = (state == RAMP) || (state == SHUTDOWN);
    // Restart the step interval on every change of ramp direction or exit from ramping.
    assign tick_clr = ((state == RAMP)     && (!bus.MEn || (ref_q == target_nxt))) ||
                      ((state == SHUTDOWN) && ( bus.MEn || (ref_q == '0)));

    ramp_tick #(.RAMP_DIV(RAMP_DIV)) u_ramp_tick (
        .clk_sys (CLKNEXYS),
        .rst_b   (MRst),
        .clr     (tick_clr),
        .en      (tick_en),
        .tick    (tick)
    );

    always_ff @(posedge CLKNEXYS or negedge MRst) begin
        if (!MRst) begin
            state    <= OFF;
            ref_q    <= '0;
            target_q <= DUTY_W'(TARGET_RST);
            numf_q   <= FREQ_W'(FREQ_RST);
            pwm_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            target_q <= target_nxt;
            numf_q   <= numf_nxt;
            case (state)
                OFF: begin
                    ref_q <= '0;
                    if (bus.MEn) begin
                        state    <= RAMP;
                        pwm_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                RAMP: begin
                    if (!bus.MEn) begin
                        state <= SHUTDOWN;
                    end else if (ref_q == target_nxt) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end else if (tick) begin
                        ref_q <= ref_step;
                        if (ref_step == target_nxt) begin
                            state  <= RUN;
                            busy_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (!bus.MEn) begin
                        state  <= SHUTDOWN;
                        busy_q <= 1'b1;
                    end else if (target_nxt != target_q) begin
                        if (bus.Modo_i) begin
                            state  <= RAMP;
                            busy_q <= 1'b1;
                        end else begin
                            ref_q <= target_nxt;
                        end
                    end
                end
                SHUTDOWN: begin
                    if (bus.MEn) begin
                        state <= RAMP;
                    end else if (ref_q == '0) begin
                        state    <= OFF;
                        pwm_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (tick) begin
                        ref_q <= ref_q - DUTY_W'(1);
                        if (ref_q == DUTY_W'(1)) begin
                            state    <= OFF;
                            pwm_en_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= OFF;
                    ref_q    <= '0;
                    pwm_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Ref_o    = ref_q;
    assign bus.Target_o = target_q;
    assign bus.numF_o   = numf_q;
    assign bus.PwmEn_o  = pwm_en_q;
    assign bus.Busy_o   = busy_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Self-checking bench for pwm_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_pwm_sequencer;
    localparam int DUTY_W = 4;
    localparam int FREQ_W = 8;
    localparam int DIV    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // behavioural model state
    int m_ref, m_tgt, m_frq, m_wait;
    bit m_act, m_slew, m_rise;

    always #5 clk = ~clk;

    pwm_seq_if #(.DUTY_W(DUTY_W), .FREQ_W(FREQ_W)) bus ();

    pwm_sequencer #(.DUTY_W(DUTY_W), .FREQ_W(FREQ_W), .RAMP_DIV(DIV)) dut (
        .CLKNEXYS (clk),
        .MRst     (rst_n),
        .bus      (bus)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit uc, input bit dc, input bit uf, input bit df);
        bus.aumC_i  = uc;
        bus.bajaC_i = dc;
        bus.aumf_i  = uf;
        bus.bajaf_i = df;
        cycle();
        bus.aumC_i  = 1'b0;
        bus.bajaC_i = 1'b0;
        bus.aumf_i  = 1'b0;
        bus.bajaf_i = 1'b0;
    endtask

    // Model: the PWM output is "active"; while "slewing" the reference moves one count
    // every DIV cycles toward the goal (setpoint when rising, zero when falling).
    task automatic model_step(input bit men, input bit modo, input bit uc, input bit dc,
                              input bit uf, input bit df);
        int t_old;
        int t_new;
        t_old = m_tgt;
        t_new = m_tgt;
        if (uc && !dc)      t_new = (m_tgt < 15) ? m_tgt + 1 : 15;
        else if (dc && !uc) t_new = (m_tgt > 0) ? m_tgt - 1 : 0;
        if (uf && !df)      m_frq = (m_frq < 200) ? m_frq + 1 : 200;
        else if (df && !uf) m_frq = (m_frq > 1) ? m_frq - 1 : 1;
        if (!m_act) begin
            m_ref = 0;
            if (men) begin m_act = 1; m_slew = 1; m_rise = 1; m_wait = DIV; end
        end else if (m_slew && m_rise) begin
            if (!men) begin
                m_rise = 0; m_wait = DIV;
            end else if (m_ref == t_new) begin
                m_slew = 0;
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_ref  = (t_new > m_ref) ? m_ref + 1 : m_ref - 1;
                    m_wait = DIV;
                    if (m_ref == t_new) m_slew = 0;
                end
            end
        end else if (m_slew) begin
            if (men) begin
                m_rise = 1; m_wait = DIV;
            end else if (m_ref == 0) begin
                m_act = 0; m_slew = 0;
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_ref  = m_ref - 1;
                    m_wait = DIV;
                    if (m_ref == 0) begin m_act = 0; m_slew = 0; end
                end
            end
        end else begin
            if (!men) begin
                m_slew = 1; m_rise = 0; m_wait = DIV;
            end else if (t_new != t_old) begin
                if (modo) begin m_slew = 1; m_rise = 1; m_wait = DIV; end
                else m_ref = t_new;
            end
        end
        m_tgt = t_new;
    endtask

    task automatic test_reset();
        #7;
        total++; if (bus.Ref_o !== 4'd0) begin bad++; $display("FAIL reset_ref got=%0d want=0", bus.Ref_o); end
        total++; if (bus.Target_o !== 4'd8) begin bad++; $display("FAIL reset_target got=%0d want=8", bus.Target_o); end
        total++; if (bus.numF_o !== 8'd100) begin bad++; $display("FAIL reset_numf got=%0d want=100", bus.numF_o); end
        total++; if (bus.PwmEn_o !== 1'b0) begin bad++; $display("FAIL reset_pwmen got=%b want=0", bus.PwmEn_o); end
        total++; if (bus.Busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.Busy_o); end
        #5 rst_n = 1'b1;
        cycle();
        total++; if (bus.PwmEn_o !== 1'b0) begin bad++; $display("FAIL idle_pwmen got=%b want=0", bus.PwmEn_o); end
    endtask

    task automatic test_soft_start();
        bus.MEn = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            cycle();
            total++; if (bus.Ref_o !== DUTY_W'(k / DIV)) begin bad++; $display("FAIL start_ref k=%0d got=%0d want=%0d", k, bus.Ref_o, k / DIV); end
            total++; if (bus.Busy_o !== (k < 32)) begin bad++; $display("FAIL start_busy k=%0d got=%b want=%b", k, bus.Busy_o, k < 32); end
            total++; if (bus.PwmEn_o !== 1'b1) begin bad++; $display("FAIL start_pwmen k=%0d got=%b want=1", k, bus.PwmEn_o); end
        end
    endtask

    task automatic test_direct();
        bus.Modo_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse(1, 0, 0, 0);
            total++; if (bus.Target_o !== DUTY_W'(9 + i)) begin bad++; $display("FAIL direct_target i=%0d got=%0d want=%0d", i, bus.Target_o, 9 + i); end
            total++; if (bus.Ref_o !== DUTY_W'(9 + i)) begin bad++; $display("FAIL direct_ref i=%0d got=%0d want=%0d", i, bus.Ref_o, 9 + i); end
            total++; if (bus.Busy_o !== 1'b0) begin bad++; $display("FAIL direct_busy i=%0d got=%b want=0", i, bus.Busy_o); end
            cycle();
        end
    endtask

    task automatic test_ramp_mode();
        int want_t;
        bus.Modo_i = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            bus.bajaC_i = (k < 4);
            cycle();
            want_t = (k < 3) ? 10 - k : 7;
            total++; if (bus.Target_o !== DUTY_W'(want_t)) begin bad++; $display("FAIL rampm_target k=%0d got=%0d want=%0d", k, bus.Target_o, want_t); end
            total++; if (bus.Ref_o !== DUTY_W'(11 - k / DIV)) begin bad++; $display("FAIL rampm_ref k=%0d got=%0d want=%0d", k, bus.Ref_o, 11 - k / DIV); end
            total++; if (bus.Busy_o !== (k < 16)) begin bad++; $display("FAIL rampm_busy k=%0d got=%b want=%b", k, bus.Busy_o, k < 16); end
        end
        bus.bajaC_i = 1'b0;
    endtask

    task automatic test_saturation();
        bus.Modo_i = 1'b0;
        for (int i = 0; i < 8; i++) pulse(1, 0, 0, 0);
        total++; if (bus.Target_o !== 4'd15) begin bad++; $display("FAIL sat_duty_top got=%0d want=15", bus.Target_o); end
        pulse(1, 0, 0, 0);
        total++; if (bus.Target_o !== 4'd15) begin bad++; $display("FAIL sat_duty_hold got=%0d want=15", bus.Target_o); end
        total++; if (bus.Ref_o !== 4'd15) begin bad++; $display("FAIL sat_duty_ref got=%0d want=15", bus.Ref_o); end
        pulse(1, 1, 0, 0);
        total++; if (bus.Target_o !== 4'd15) begin bad++; $display("FAIL sat_duty_both got=%0d want=15", bus.Target_o); end
        for (int i = 0; i < 15; i++) pulse(0, 1, 0, 0);
        total++; if (bus.Target_o !== 4'd0) begin bad++; $display("FAIL sat_duty_zero got=%0d want=0", bus.Target_o); end
        pulse(0, 1, 0, 0);
        total++; if (bus.Target_o !== 4'd0) begin bad++; $display("FAIL sat_duty_low got=%0d want=0", bus.Target_o); end
        total++; if (bus.Ref_o !== 4'd0) begin bad++; $display("FAIL sat_duty_lref got=%0d want=0", bus.Ref_o); end
        for (int i = 0; i < 8; i++) pulse(1, 0, 0, 0);
        total++; if (bus.Ref_o !== 4'd8) begin bad++; $display("FAIL sat_duty_back got=%0d want=8", bus.Ref_o); end
        for (int i = 0; i < 100; i++) pulse(0, 0, 1, 0);
        total++; if (bus.numF_o !== 8'd200) begin bad++; $display("FAIL sat_freq_top got=%0d want=200", bus.numF_o); end
        pulse(0, 0, 1, 0);
        total++; if (bus.numF_o !== 8'd200) begin bad++; $display("FAIL sat_freq_hold got=%0d want=200", bus.numF_o); end
        pulse(0, 0, 1, 1);
        total++; if (bus.numF_o !== 8'd200) begin bad++; $display("FAIL sat_freq_both got=%0d want=200", bus.numF_o); end
        for (int i = 0; i < 199; i++) pulse(0, 0, 0, 1);
        total++; if (bus.numF_o !== 8'd1) begin bad++; $display("FAIL sat_freq_min got=%0d want=1", bus.numF_o); end
        pulse(0, 0, 0, 1);
        total++; if (bus.numF_o !== 8'd1) begin bad++; $display("FAIL sat_freq_low got=%0d want=1", bus.numF_o); end
    endtask

    task automatic test_soft_stop();
        bus.MEn = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            cycle();
            total++; if (bus.Ref_o !== DUTY_W'(8 - k / DIV)) begin bad++; $display("FAIL stop_ref k=%0d got=%0d want=%0d", k, bus.Ref_o, 8 - k / DIV); end
            total++; if (bus.PwmEn_o !== 1'b1) begin bad++; $display("FAIL stop_pwmen k=%0d got=%b want=1", k, bus.PwmEn_o); end
        end
        bus.MEn = 1'b1;
        for (int j = 0; j <= 16; j++) begin
            cycle();
            total++; if (bus.Ref_o !== DUTY_W'(4 + j / DIV)) begin bad++; $display("FAIL restart_ref j=%0d got=%0d want=%0d", j, bus.Ref_o, 4 + j / DIV); end
            total++; if (bus.Busy_o !== (j < 16)) begin bad++; $display("FAIL restart_busy j=%0d got=%b want=%b", j, bus.Busy_o, j < 16); end
        end
        bus.MEn = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            cycle();
            total++; if (bus.Ref_o !== DUTY_W'(8 - k / DIV)) begin bad++; $display("FAIL off_ref k=%0d got=%0d want=%0d", k, bus.Ref_o, 8 - k / DIV); end
            total++; if (bus.PwmEn_o !== (k < 32)) begin bad++; $display("FAIL off_pwmen k=%0d got=%b want=%b", k, bus.PwmEn_o, k < 32); end
            total++; if (bus.Busy_o !== (k < 32)) begin bad++; $display("FAIL off_busy k=%0d got=%b want=%b", k, bus.Busy_o, k < 32); end
        end
    endtask

    task automatic test_async_reset();
        pulse(1, 0, 0, 0);
        bus.MEn = 1'b1;
        for (int k = 0; k <= 20; k++) cycle();
        total++; if (bus.Ref_o !== 4'd5) begin bad++; $display("FAIL areset_pre_ref got=%0d want=5", bus.Ref_o); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.Ref_o !== 4'd0) begin bad++; $display("FAIL areset_ref got=%0d want=0", bus.Ref_o); end
        total++; if (bus.Target_o !== 4'd8) begin bad++; $display("FAIL areset_target got=%0d want=8", bus.Target_o); end
        total++; if (bus.numF_o !== 8'd100) begin bad++; $display("FAIL areset_numf got=%0d want=100", bus.numF_o); end
        total++; if (bus.PwmEn_o !== 1'b0) begin bad++; $display("FAIL areset_pwmen got=%b want=0", bus.PwmEn_o); end
        total++; if (bus.Busy_o !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b want=0", bus.Busy_o); end
        bus.MEn = 1'b0;
        cycle();
        total++; if (bus.Ref_o !== 4'd0) begin bad++; $display("FAIL areset_hold_ref got=%0d want=0", bus.Ref_o); end
    endtask

    task automatic test_random();
        bit men, modo, uc, dc, uf, df;
        men = 0; modo = 0;
        m_ref = 0; m_tgt = 8; m_frq = 100; m_wait = 0;
        m_act = 0; m_slew = 0; m_rise = 0;
        #2 rst_n = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(29) == 0) men = !men;
            if ($urandom_range(24) == 0) modo = !modo;
            uc = ($urandom_range(5) == 0);
            dc = ($urandom_range(5) == 0);
            uf = ($urandom_range(5) == 0);
            df = ($urandom_range(5) == 0);
            bus.MEn = men; bus.Modo_i = modo;
            bus.aumC_i = uc; bus.bajaC_i = dc; bus.aumf_i = uf; bus.bajaf_i = df;
            model_step(men, modo, uc, dc, uf, df);
            cycle();
            total++; if (bus.Ref_o !== DUTY_W'(m_ref)) begin bad++; $display("FAIL rand_ref n=%0d got=%0d want=%0d", n, bus.Ref_o, m_ref); end
            total++; if (bus.Target_o !== DUTY_W'(m_tgt)) begin bad++; $display("FAIL rand_target n=%0d got=%0d want=%0d", n, bus.Target_o, m_tgt); end
            total++; if (bus.numF_o !== FREQ_W'(m_frq)) begin bad++; $display("FAIL rand_numf n=%0d got=%0d want=%0d", n, bus.numF_o, m_frq); end
            total++; if (bus.PwmEn_o !== m_act) begin bad++; $display("FAIL rand_pwmen n=%0d got=%b want=%b", n, bus.PwmEn_o, m_act); end
            total++; if (bus.Busy_o !== m_slew) begin bad++; $display("FAIL rand_busy n=%0d got=%b want=%b", n, bus.Busy_o, m_slew); end
        end
        bus.aumC_i = 0; bus.bajaC_i = 0; bus.aumf_i = 0; bus.bajaf_i = 0;
    endtask

    initial begin
        bus.MEn     = 1'b0;
        bus.Modo_i  = 1'b0;
        bus.aumC_i  = 1'b0;
        bus.bajaC_i = 1'b0;
        bus.aumf_i  = 1'b0;
        bus.bajaf_i = 1'b0;
        test_reset();
        test_soft_start();
        test_direct();
        test_ramp_mode();
        test_saturation();
        test_soft_stop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_sequencer.md
# pwm_sequencer

Sequencing controller between the debounced button front-end and the PWM datapath (frequency selector + PWM comparator). Holds the duty setpoint and frequency index, soft-starts and soft-stops the applied duty on enable changes, and in ramp mode slews duty toward the setpoint at a prescaled rate instead of jumping. Drives the PWM block's duty reference, frequency index and enable.

## Interface
Parameters:
- DUTY_W, 4, width of duty setpoint/reference
- FREQ_W, 8, width of frequency index
- FREQ_MIN, 1, lowest legal frequency index
- FREQ_MAX, 200, highest legal frequency index
- FREQ_RST, 100, frequency index after reset
- TARGET_RST, 8, duty setpoint after reset
- RAMP_DIV, 50000, clock cycles per ramp step (≥2)

Ports:
- CLKNEXYS  in  1  system clock; one clock domain, all logic on rising edge
- MRst  in  1  reset, asynchronous, active-low
- MEn  in  1  motor enable level
- Modo_i  in  1  0 = direct (setpoint changes applied immediately), 1 = ramp
- aumC_i  in  1  duty-up pulse, one cycle, already debounced
- bajaC_i  in  1  duty-down pulse, one cycle
- aumf_i  in  1  frequency-up pulse, one cycle
- bajaf_i  in  1  frequency-down pulse, one cycle
- Ref_o  out  DUTY_W  applied duty reference to PWM block
- Target_o  out  DUTY_W  duty setpoint
- numF_o  out  FREQ_W  frequency index to frequency selector
- PwmEn_o  out  1  PWM enable (0 forces PWM output low downstream)
- Busy_o  out  1  high while Ref_o ≠ its destination (ramping)

## Operation
- States: OFF, RAMP, RUN, SHUTDOWN. Reset → OFF.
- Reset values: Ref_o=0, Target_o=TARGET_RST, numF_o=FREQ_RST, PwmEn_o=0, Busy_o=0, prescaler=0.
- OFF: Ref_o=0, PwmEn_o=0. MEn=1 → RAMP.
- RAMP: PwmEn_o=1, Busy_o=1. On each tick Ref_o steps ±1 toward Target_o. Ref_o==Target_o → RUN. MEn=0 → SHUTDOWN.
- RUN: PwmEn_o=1, Ref_o tracks Target_o. Setpoint change with Modo_i=0: Ref_o takes new value on same edge as Target_o. With Modo_i=1: → RAMP. MEn=0 → SHUTDOWN.
- SHUTDOWN: PwmEn_o=1, Busy_o=1, Ref_o steps −1 per tick; Ref_o==0 → OFF (PwmEn_o=0 from that edge). MEn=1 → RAMP from current Ref_o.
- Soft-start/soft-stop ramp regardless of Modo_i.
- Duty buttons: accepted in every state; Target_o saturates at 0 and 2^DUTY_W−1. aumC_i and bajaC_i same cycle → no change.
- Frequency buttons: accepted in every state; numF_o saturates at FREQ_MIN/FREQ_MAX. Both same cycle → no change.
- Setpoint change during RAMP/SHUTDOWN updates Target_o only; RAMP retargets on next tick.
- Tick: prescaler counts 0..RAMP_DIV−1, tick on terminal count. Cleared on every entry to RAMP or SHUTDOWN, so first step occurs RAMP_DIV cycles after entry. Prescaler idle (held 0) in OFF and RUN.

## Timing
- Button pulse sampled at edge n → Target_o/numF_o valid after edge n.
- MEn rise at edge n → state RAMP, PwmEn_o=1 after edge n; first Ref_o step after edge n+RAMP_DIV.
- Ramp from a to b takes |a−b|·RAMP_DIV cycles; RUN entered on the edge Ref_o reaches b.
- Target_o == Ref_o == 0 with MEn=1: RAMP → RUN in one cycle, PwmEn_o stays 1.
- MRst low anytime: all outputs to reset values immediately (asynchronous), mid-ramp state discarded.

## Structure
- Package pwm_seq_pkg: state enum (OFF, RAMP, RUN, SHUTDOWN), default constants (TARGET_RST, FREQ_RST, FREQ_MIN, FREQ_MAX).
- Sub-module ramp_tick: RAMP_DIV prescaler with synchronous clear and enable, one-cycle tick output.
- Top holds FSM, setpoint and frequency saturating up/down registers.

## Test plan
(RAMP_DIV=4 for simulation)
- Reset, MEn=1, Target=8 → Ref_o 0→8 one step per 4 cycles, RUN after 32 cycles, Busy_o then 0.
- RUN, Modo_i=0, three aumC_i pulses → Target_o and Ref_o 9,10,11 on cycle after each pulse, no ramp.
- RUN at 11, Modo_i=1, bajaC_i ×4 → Target_o=7 immediately, Ref_o ramps 11→7 in 16 cycles.
- Target=15, aumC_i → stays 15; numF_o=200, aumf_i → stays 200; aumf_i+bajaf_i together → unchanged.
- MEn=0 at Ref_o=8 → ramp to 0 in 32 cycles, PwmEn_o=0 at OFF; MEn reasserted at Ref_o=4 → ramps back up from 4.
- MRst low mid-ramp at Ref_o=5 → Ref_o=0, Target_o=8, numF_o=100, PwmEn_o=0 without clock edge.
